// File: rtl/sha256_msg_ctrl.sv
// rtl/sha256_msg_ctrl.sv - collects and pads one message block for the sha256 core and streams the digest out
// Optional SHA256_HEX_OUT_EN: emit the digest as 64 lowercase hex characters plus 8'h0A instead of 32 raw bytes.
module sha256_msg_ctrl #(
    parameter int          MAX_BYTES = 55,
    parameter logic [7:0]  TERM_BYTE = 8'h0A
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [7:0]   RxData,
    input  logic         RxValid,
    output logic         Start,
    output logic [511:0] Chunk,
    input  logic [255:0] Digest,
    input  logic         DigestReady,
    output logic [7:0]   TxData,
    output logic         TxValid,
    input  logic         TxReady,
    output logic         Busy,
    output logic         Overflow
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_SEND    = 2'd3;

`ifdef SHA256_HEX_OUT_EN
    localparam logic [6:0] OUT_LAST  = 7'd64;
    localparam int         OUT_SHIFT = 4;
`else
    localparam logic [6:0] OUT_LAST  = 7'd31;
    localparam int         OUT_SHIFT = 8;
`endif

    logic [1:0]   state;
    logic [511:0] buffer;
    logic [5:0]   count;
    logic [6:0]   out_idx;
    logic [255:0] digest_sr;
    logic         overflow;
    logic         rx_term;
    logic [8:0]   wr_base;

    assign rx_term = (RxData == TERM_BYTE);
    // MSB index of byte slot 'count' inside the block
    assign wr_base = 9'd511 - {count, 3'b000};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_COLLECT;
            buffer    <= '0;
            count     <= '0;
            out_idx   <= '0;
            digest_sr <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (RxValid) begin
                        if (!rx_term) begin
                            if (int'(count) < MAX_BYTES) begin
                                buffer[wr_base -: 8] <= RxData;
                                count                <= count + 6'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (overflow) begin
                            buffer   <= '0;
                            count    <= '0;
                            overflow <= 1'b0;
                        end else begin
                            buffer[wr_base -: 8] <= 8'h80;
                            buffer[63:0]         <= {55'd0, count, 3'b000};
                            state                <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: state <= S_WAIT;
                S_WAIT: begin
                    if (DigestReady) begin
                        digest_sr <= Digest;
                        out_idx   <= '0;
                        state     <= S_SEND;
                    end
                end
                default: begin
                    if (TxReady) begin
                        digest_sr <= digest_sr << OUT_SHIFT;
                        if (out_idx == OUT_LAST) begin
                            state   <= S_COLLECT;
                            buffer  <= '0;
                            count   <= '0;
                            out_idx <= '0;
                        end else begin
                            out_idx <= out_idx + 7'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SHA256_HEX_OUT_EN
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    assign TxData = !TxValid ? 8'h00 :
                    (out_idx == OUT_LAST) ? 8'h0A : hex_char(digest_sr[255:252]);
`else
    assign TxData = TxValid ? digest_sr[255:248] : 8'h00;
`endif

    assign Start    = (state == S_LAUNCH);
    assign Busy     = (state != S_COLLECT);
    assign TxValid  = (state == S_SEND);
    assign Chunk    = buffer;
    assign Overflow = overflow;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// tb/tb_sha256_msg_ctrl.sv - directed scoreboard bench for sha256_msg_ctrl with a behavioural core stand-in
`timescale 1ns/1ps
module tb_sha256_msg_ctrl;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic [7:0]   RxData = 8'h00;
    logic         RxValid = 1'b0;
    logic         Start;
    logic [511:0] Chunk;
    logic [255:0] Digest = '0;
    logic         DigestReady = 1'b0;
    logic [7:0]   TxData;
    logic         TxValid;
    logic         TxReady = 1'b1;
    logic         Busy;
    logic         Overflow;

    always #5 Clk = ~Clk;

    sha256_msg_ctrl dut (
        .Clk(Clk), .Reset(Reset), .RxData(RxData), .RxValid(RxValid),
        .Start(Start), .Chunk(Chunk), .Digest(Digest), .DigestReady(DigestReady),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .Busy(Busy), .Overflow(Overflow)
    );

    localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] EMPTY_C = {8'h80, 504'd0};
    localparam logic [511:0] ABC_C   = {32'h61626380, 416'd0, 64'd24};
`ifdef SHA256_HEX_OUT_EN
    localparam int N_OUT = 65;
`else
    localparam int N_OUT = 32;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stand-in for the hash core: recognises the two reference blocks only
    function automatic logic [255:0] core_fn(input logic [511:0] c);
        if (c == EMPTY_C) return EMPTY_D;
        if (c == ABC_C)   return ABC_D;
        return ~c[511:256];
    endfunction

    function automatic logic [7:0] hex_c(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h61 + {4'h0, n} - 8'd10);
    endfunction

    task automatic push_digest(input logic [255:0] d);
`ifdef SHA256_HEX_OUT_EN
        for (int i = 0; i < 64; i++) exp_q.push_back(hex_c(d[255 - 4*i -: 4]));
        exp_q.push_back(8'h0A);
`else
        for (int i = 0; i < 32; i++) exp_q.push_back(d[255 - 8*i -: 8]);
`endif
    endtask

    task automatic rx(input logic [7:0] b);
        RxData = b;
        RxValid = 1'b1;
        @(negedge Clk);
        RxValid = 1'b0;
    endtask

    task automatic send_abc();
        rx(8'h61); rx(8'h62); rx(8'h63); rx(8'h0A);
    endtask

    // Entered at the negedge right after the delimiter edge
    task automatic launch(input logic [511:0] exp_chunk, input logic [255:0] exp_d, input logic inject);
        check("start_high", 512'(Start), 512'(1));
        check("busy_launch", 512'(Busy), 512'(1));
        check("chunk", Chunk, exp_chunk);
        push_digest(exp_d);
        DigestReady = 1'b0;
        @(negedge Clk);
        check("start_width", 512'(Start), 512'(0));
        for (int i = 0; i < 3; i++) begin
            if (inject) begin
                RxValid = 1'b1;
                RxData = (i == 1) ? 8'h0A : 8'($urandom);
            end
            @(negedge Clk);
        end
        RxValid = 1'b0;
        Digest = core_fn(Chunk);
        DigestReady = 1'b1;
        @(negedge Clk);
        check("first_valid", 512'(TxValid), 512'(1));
    endtask

    task automatic drain(input int n, input logic [3:0] pat, input logic inject, output int cyc);
        int got;
        logic prev_stall;
        logic [7:0] prev;
        got = 0; cyc = 0; prev_stall = 1'b0; prev = 8'h00;
        while (got < n && cyc < 400) begin
            if (prev_stall) check("tx_hold", 512'(TxData), 512'(prev));
            TxReady = pat[cyc[1:0]];
            if (inject) begin
                RxValid = 1'b1;
                RxData = 8'($urandom);
            end
            if (TxValid && TxReady) begin
                if (exp_q.size() == 0) check("tx_extra", 512'(1), 512'(0));
                else check("tx_byte", 512'(TxData), 512'(exp_q.pop_front()));
                got++;
            end
            prev_stall = TxValid && !TxReady;
            prev = TxData;
            cyc++;
            @(negedge Clk);
        end
        RxValid = 1'b0;
        TxReady = 1'b1;
        if (got < n) check("tx_timeout", 512'(got), 512'(n));
    endtask

    task automatic end_check();
        check("done_busy", 512'(Busy), 512'(0));
        check("done_txvalid", 512'(TxValid), 512'(0));
        check("done_chunk_clear", Chunk, 512'(0));
        check("done_overflow", 512'(Overflow), 512'(0));
        check("sb_empty", 512'(exp_q.size()), 512'(0));
    endtask

    initial begin
        int cyc;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_start", 512'(Start), 512'(0));
        check("rst_chunk", Chunk, 512'(0));
        check("rst_txdata", 512'(TxData), 512'(0));
        check("rst_txvalid", 512'(TxValid), 512'(0));
        check("rst_busy", 512'(Busy), 512'(0));
        check("rst_overflow", 512'(Overflow), 512'(0));
        Reset = 1'b0;
        @(negedge Clk);

        // Empty message
        rx(8'h0A);
        launch(EMPTY_C, EMPTY_D, 1'b0);
        drain(N_OUT, 4'b1111, 1'b0, cyc);
        check("tx_cycles", 512'(cyc), 512'(N_OUT));
        end_check();

        // "abc"
        send_abc();
        launch(ABC_C, ABC_D, 1'b0);
        drain(N_OUT, 4'b1111, 1'b0, cyc);
        end_check();

        // 56 bytes overflow, then discard on delimiter
        for (int i = 0; i < 56; i++) begin
            rx(8'h78);
            if (i == 54) check("ovf_at_55", 512'(Overflow), 512'(0));
        end
        check("ovf_at_56", 512'(Overflow), 512'(1));
        check("ovf_no_busy", 512'(Busy), 512'(0));
        rx(8'h0A);
        check("ovf_no_start", 512'(Start), 512'(0));
        check("ovf_cleared", 512'(Overflow), 512'(0));
        check("ovf_buf_clear", Chunk, 512'(0));
        @(negedge Clk);
        check("ovf_no_start2", 512'(Start), 512'(0));
        check("ovf_idle", 512'(Busy), 512'(0));
        send_abc();
        launch(ABC_C, ABC_D, 1'b0);
        drain(N_OUT, 4'b1111, 1'b0, cyc);
        end_check();

        // TxReady stall pattern 1,0,0,1
        send_abc();
        launch(ABC_C, ABC_D, 1'b0);
        drain(N_OUT, 4'b1001, 1'b0, cyc);
        end_check();

        // Bytes injected during WAIT and SEND
        send_abc();
        launch(ABC_C, ABC_D, 1'b1);
        drain(N_OUT, 4'b1111, 1'b1, cyc);
        end_check();

        // Reset mid-SEND after 10 bytes
        send_abc();
        launch(ABC_C, ABC_D, 1'b0);
        drain(10, 4'b1111, 1'b0, cyc);
        Reset = 1'b1;
        DigestReady = 1'b0;
        @(negedge Clk);
        check("rst_send_txvalid", 512'(TxValid), 512'(0));
        check("rst_send_busy", 512'(Busy), 512'(0));
        check("rst_send_chunk", Chunk, 512'(0));
        Reset = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        send_abc();
        launch(ABC_C, ABC_D, 1'b0);
        drain(N_OUT, 4'b1111, 1'b0, cyc);
        end_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
